// File: rtl/riscv_pkg.sv
// Shared core constants: ALU control codes and default datapath widths.
// Imported by the execute-stage issue register and its bypass mux.
package riscv_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand writeback bypass: compare source index against wb_rd, select.
// Bypass is compiled in only when FORWARD_EN is defined; else pass-through.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] value
);

`ifdef FORWARD_EN
    logic hit;

    // x0 is hardwired zero, so it never takes a bypass
    assign hit   = wb_valid && (wb_rd != '0) && (wb_rd == addr);
    assign value = hit ? wb_data : data;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_valid, wb_rd, wb_data, addr};
    assign value     = data;
`endif

endmodule

// File: rtl/ex_issue_reg.sv
// Decode-to-ALU issue register: valid/ready handshake, operand select,
// optional writeback bypass at capture and while held (FORWARD_EN).
module ex_issue_reg
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  ALUsrc,
    input  logic [2:0]            ALUctrl_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                  reg_write_in,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  reg_write
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] rs2v_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  src_q;
    logic [2:0]            ctrl_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rw_q;

    logic                  capture;
    logic [DATA_WIDTH-1:0] op1_nxt;
    logic [DATA_WIDTH-1:0] op2_nxt;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // One mux per operand: the incoming fields on capture, else the held ones
    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd1 (
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .addr     (capture ? rs1_addr : rs1_q),
        .data     (capture ? rs1_data : op1_q),
        .value    (op1_nxt)
    );

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd2 (
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .addr     (capture ? rs2_addr : rs2_q),
        .data     (capture ? rs2_data : rs2v_q),
        .value    (op2_nxt)
    );

    // Occupancy: flush wins, then capture, then drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Payload: load on capture, refresh operands from bypass while occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            op1_q  <= '0;
            rs2v_q <= '0;
            imm_q  <= '0;
            src_q  <= 1'b0;
            ctrl_q <= ALU_ADD;
            rd_q   <= '0;
            rw_q   <= 1'b0;
        end else if (capture) begin
            rs1_q  <= rs1_addr;
            rs2_q  <= rs2_addr;
            op1_q  <= op1_nxt;
            rs2v_q <= op2_nxt;
            imm_q  <= imm;
            src_q  <= ALUsrc;
            ctrl_q <= ALUctrl_in;
            rd_q   <= rd_addr_in;
            rw_q   <= reg_write_in;
        end else if (valid_q) begin
            op1_q  <= op1_nxt;
            rs2v_q <= op2_nxt;
        end
    end

    assign out_valid = valid_q;
    assign ALUop1    = op1_q;
    assign ALUop2    = src_q ? imm_q : rs2v_q;
    assign ALUctrl   = ctrl_q;
    assign rd_addr   = rd_q;
    assign reg_write = rw_q;

endmodule

// File: tb/tb_ex_issue_reg.sv
// Directed bench for ex_issue_reg with an expected-result queue.
// Bypass expectations follow FORWARD_EN when the bench is built with it.
module tb_ex_issue_reg;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [2:0]    ctrl;
        logic [AW-1:0] rd;
        logic          rw;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [DW-1:0] rs1_data, rs2_data, imm;
    logic          ALUsrc;
    logic [2:0]    ALUctrl_in;
    logic [AW-1:0] rd_addr_in;
    logic          reg_write_in;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ALUop1, ALUop2;
    logic [2:0]    ALUctrl;
    logic [AW-1:0] rd_addr;
    logic          reg_write;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t hd;

    always #5 clk = ~clk;

    ex_issue_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .ALUsrc       (ALUsrc),
        .ALUctrl_in   (ALUctrl_in),
        .rd_addr_in   (rd_addr_in),
        .reg_write_in (reg_write_in),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALUop1       (ALUop1),
        .ALUop2       (ALUop2),
        .ALUctrl      (ALUctrl),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write)
    );

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a,
                                          input logic [DW-1:0] d);
        if (FWD && wb_valid && wb_rd != '0 && wb_rd == a) return wb_data;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                         input logic [DW-1:0] im, input logic src,
                         input logic [2:0] c, input logic [AW-1:0] rd,
                         input logic rw);
        in_valid     = 1'b1;
        rs1_addr     = a1;
        rs1_data     = d1;
        rs2_addr     = a2;
        rs2_data     = d2;
        imm          = im;
        ALUsrc       = src;
        ALUctrl_in   = c;
        rd_addr_in   = rd;
        reg_write_in = rw;
    endtask

    task automatic push_exp();
        exp_t e;
        e.op1  = fwd(rs1_addr, rs1_data);
        e.op2  = ALUsrc ? imm : fwd(rs2_addr, rs2_data);
        e.ctrl = ALUctrl_in;
        e.rd   = rd_addr_in;
        e.rw   = reg_write_in;
        q.push_back(e);
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_valid"}, DW'(out_valid), DW'(1'b1));
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, DW'(0), DW'(1));
        end else begin
            hd = q[0];
            chk({tag, "_op1"}, ALUop1, hd.op1);
            chk({tag, "_op2"}, ALUop2, hd.op2);
            chk({tag, "_ctrl"}, DW'(ALUctrl), DW'(hd.ctrl));
            chk({tag, "_rd"}, DW'(rd_addr), DW'(hd.rd));
            chk({tag, "_rw"}, DW'(reg_write), DW'(hd.rw));
        end
    endtask

    task automatic pop();
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        rs1_data = '0; rs2_data = '0; imm = '0;
        ALUsrc = 1'b0; ALUctrl_in = '0;
        rd_addr_in = '0; reg_write_in = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        #3;
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_op1", ALUop1, '0);
        chk("rst_op2", ALUop2, '0);
        chk("rst_ctrl", DW'(ALUctrl), DW'(0));
        chk("rst_rd", DW'(rd_addr), DW'(0));
        chk("rst_rw", DW'(reg_write), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // basic register-register issue
        drive(5'd1, 32'd5, 5'd2, 32'd3, 32'd0, 1'b0, 3'b001, 5'd3, 1'b1);
        push_exp();
        step();
        check_head("basic");
        pop();

        // immediate operand, back-to-back
        drive(5'd1, 32'd8, 5'd2, 32'd7, 32'hFFFF_FFFC, 1'b1, 3'b000,
              5'd4, 1'b1);
        push_exp();
        step();
        check_head("imm");
        pop();

        // backpressure
        drive(5'd5, 32'd10, 5'd6, 32'd20, 32'd0, 1'b0, 3'b010, 5'd7, 1'b1);
        push_exp();
        step();
        check_head("bp_first");
        out_ready = 1'b0;
        drive(5'd8, 32'd30, 5'd9, 32'd40, 32'd0, 1'b0, 3'b011, 5'd10, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", DW'(in_ready), DW'(0));
            step();
            check_head("bp_hold");
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", DW'(in_ready), DW'(1));
        pop();
        push_exp();
        step();
        check_head("bp_second");

        // flush with a held entry and an incoming one
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check_head("fl_hold");
        drive(5'd11, 32'd50, 5'd12, 32'd60, 32'd0, 1'b0, 3'b101, 5'd13, 1'b1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", DW'(in_ready), DW'(0));
        step();
        pop();
        chk("fl_valid", DW'(out_valid), DW'(0));
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_dropped", DW'(out_valid), DW'(0));
        out_ready = 1'b1;

        // writeback bypass at capture and while held
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_data  = 32'd9;
        drive(5'd4, 32'd1, 5'd6, 32'd2, 32'd0, 1'b0, 3'b011, 5'd14, 1'b1);
        push_exp();
        step();
        check_head("byp_cap");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wb_data   = 32'd11;
        step();
        if (FWD) q[0].op1 = 32'd11;
        check_head("byp_hold1");
        wb_rd   = 5'd6;
        wb_data = 32'd77;
        step();
        if (FWD) q[0].op2 = 32'd77;
        check_head("byp_hold2");

        // x0 never bypassed; drain and capture on the same edge
        wb_rd     = 5'd0;
        wb_data   = 32'hAA;
        out_ready = 1'b1;
        drive(5'd0, 32'h55, 5'd7, 32'h66, 32'd0, 1'b0, 3'b000, 5'd15, 1'b1);
        push_exp();
        pop();
        step();
        check_head("x0_cap");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check_head("x0_hold");
        wb_valid = 1'b0;

        // unused ALU code passes straight through
        out_ready = 1'b1;
        drive(5'd2, 32'h1234, 5'd3, 32'h5678, 32'd0, 1'b0, 3'b111,
              5'd16, 1'b0);
        push_exp();
        pop();
        step();
        check_head("ctrl7");

        // reset while holding an entry
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check_head("rst_hold");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", DW'(out_valid), DW'(0));
        chk("rst2_op1", ALUop1, '0);
        chk("rst2_op2", ALUop2, '0);
        chk("rst2_ctrl", DW'(ALUctrl), DW'(0));
        chk("rst2_in_ready", DW'(in_ready), DW'(1));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst2_idle", DW'(out_valid), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_issue_reg.md
# ex_issue_reg

Single-entry pipeline register between decode and the ALU. It captures decoded operands, the 3-bit ALU control code and destination info under a valid/ready handshake. It selects register-vs-immediate for the second operand and optionally bypasses writeback data into operands, both at capture and while held. It presents registered, stable ALUop1/ALUop2/ALUctrl to the combinational ALU and supports flush for taken branches.

## Interface
- DATA_WIDTH, 32, operand/immediate width
- ADDR_WIDTH, 5, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs1_addr, rs2_addr  in  ADDR_WIDTH  source register indices
- rs1_data, rs2_data  in  DATA_WIDTH  register file read data
- imm  in  DATA_WIDTH  sign-extended immediate
- ALUsrc  in  1  1: ALUop2 = imm; 0: ALUop2 = rs2
- ALUctrl_in  in  3  ALU operation code
- rd_addr_in  in  ADDR_WIDTH  destination register
- reg_write_in  in  1  instruction writes rd
- wb_valid  in  1  writeback active this cycle
- wb_rd  in  ADDR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback value
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  ALU inputs hold a valid instruction
- out_ready  in  1  downstream consumes this cycle
- ALUop1, ALUop2  out  DATA_WIDTH  ALU operands
- ALUctrl  out  3  ALU operation code
- rd_addr  out  ADDR_WIDTH  destination register
- reg_write  out  1  write-enable, qualified by out_valid downstream

## Operation
- Storage: out_valid, rs1/rs2 addrs, op1 value, rs2 value, imm, ALUsrc, ALUctrl, rd_addr, reg_write.
- in_ready = !out_valid || out_ready (combinational; no dependency on in_valid).
- Capture when in_valid && in_ready && !flush: all fields load; out_valid <= 1.
- Drain when out_valid && out_ready and no capture: out_valid <= 0. Simultaneous drain+capture: new entry loads, out_valid stays 1.
- Hold when out_valid && !out_ready: entry stays put, except bypass updates.
- flush: out_valid <= 0 next edge; an incoming in_valid that same cycle is dropped (no capture). in_ready is unaffected by flush.
- ALUop1 = stored op1; ALUop2 = ALUsrc ? stored imm : stored rs2 value.
- Bypass match: wb_valid && wb_rd != 0 && wb_rd == source addr. At capture, a matching wb_data replaces rs1_data/rs2_data. While held, a match overwrites the stored value. Register 0 is never bypassed.
- ALUctrl is passed through unchecked. Unused codes reach the ALU, which yields 0.
- Fields other than out_valid are don't-care while out_valid = 0 but must not be X after reset.

## Timing
- Latency: 1 cycle from capture edge to out_valid/operands visible.
- Throughput: 1 instruction/cycle with out_ready held high.
- Reset (async assert, sync-safe deassert): out_valid=0, ALUop1=0, ALUop2=0, ALUctrl=3'b000, rd_addr=0, reg_write=0. in_ready = 1 while in reset.
- Reset mid-hold: entry lost; no output until next capture.
- Outputs are register-driven only; no combinational path in_* -> ALUop*/ALUctrl.

## Configuration
- FORWARD_EN defined: writeback bypass active as above.
- FORWARD_EN undefined: wb_* ports present but ignored. Operands are exactly the captured rs1_data/rs2_data, and RAW hazards are the compiler's responsibility.

## Structure
- Shared package riscv_pkg: ALU control constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101, and default widths.
- One sub-module: fwd_mux, the per-operand bypass compare/select. It is instantiated twice for capture and twice for hold, or once per operand with shared select.

## Test plan
- Reset: rst_n low mid-stream -> out_valid=0, ALUop1/ALUop2=0, ALUctrl=0 immediately; in_ready=1.
- Basic issue: in_valid, rs1_data=5, rs2_data=3, ALUsrc=0, ALUctrl_in=001 -> next cycle out_valid=1, ALUop1=5, ALUop2=3, ALUctrl=001.
- Immediate: ALUsrc=1, imm=0xFFFFFFFC, rs2_data=7 -> ALUop2=0xFFFFFFFC.
- Backpressure: out_ready=0 for 3 cycles -> in_ready=0, outputs stable. out_ready=1 with in_valid -> new entry loads the same edge.
- Bypass (FORWARD_EN): capture rs1_addr=4, rs1_data=1 while wb_valid, wb_rd=4, wb_data=9 -> ALUop1=9. While held, wb_rd=4, wb_data=11 -> ALUop1=11. wb_rd=0 with rs1_addr=0 -> no change.
- Flush: flush with in_valid=1 and a held entry -> out_valid=0 next cycle, incoming instruction never appears.
